single_ch_dcfifo_s: RTL and testbench
=====================================

Name: single_ch_dcfifo_s

Overview:
- Single-channel, fixed-depth streaming FIFO (delay line) on one clock domain.
- Every enqueue writes one DW-bit word and emits the word written exactly 2^LEN_LOG enqueues earlier.
- Used as a programmable-length data delay or skid element in streaming datapaths; no dequeue handshake, so the stream self-drains as new data arrives.

Parameters:
- DW, 32, data width in bits.
- LEN_LOG, 2, log2 of the depth; depth D = 2^LEN_LOG; legal range 1..12.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RST_X  input  1  asynchronous reset, active low.
- CLR  input  1  synchronous clear, active high; tie to 0 when unused.
- enq  input  1  enqueue strobe; din is accepted on a rising edge while high.
- din  input  DW  write data.
- dot  output  DW  read data: the word displaced by the latest enqueue.

Behaviour:
- Interface fixed: one clock (CLK); reset RST_X is asynchronous and active-low.
- State:
  - storage mem[0..D-1], each DW bits
  - write pointer wp, LEN_LOG bits
  - fill counter fc, LEN_LOG+1 bits, saturating at D
  - output register dot
- Reset (RST_X=0, asynchronous): wp=0, fc=0, dot=0. mem contents need not be reset.
- CLR=1 at a rising edge: same effect as reset, synchronously. CLR has priority over enq; a coincident enq is discarded.
- enq=1, CLR=0 at a rising edge, evaluated in this order:
  1. Read before write: dot <= (fc==D) ? mem[wp] : 0.
  2. mem[wp] <= din.
  3. wp <= wp+1, wrapping modulo D.
  4. fc <= min(fc+1, D).
- enq=0: all state holds; dot keeps its last value.
- Latency: the word accepted on enqueue k appears on dot right after the rising edge of enqueue k+D. It stays there until the next enqueue.
- Fill phase: during the first D enqueues after reset or clear, dot shows 0. It never exposes uninitialised memory.
- Wrap-around: the pointer wraps silently. Overflow and underflow cannot occur; there are no status flags.
- Consumers sample dot on the falling edge or the next cycle. dot is glitch-free because it is a register.
- Reset mid-stream: all buffered words are lost, and the fill phase restarts from 0.

Optional Feature:
- Macro SINGLE_CH_DCFIFO_S_OUTREG_EN.
- Defined (default build): dot is registered exactly as described above.
- Undefined: dot is combinational, equal to (fc==D) ? mem[wp] : 0. It then shows the word that the next enqueue will displace, one enqueue earlier than the registered build.
- Reset, clear and fill gating are otherwise identical in both builds.
- mem stays a synchronous-write array in both builds.

Test Plan:
- Reset: hold RST_X=0 asynchronously mid-cycle -> dot=0 immediately. Release, enq=0 for 10 cycles -> dot stays 0.
- Fill and steady stream (DW=32, LEN_LOG=2): enq=1 every cycle, din=1,2,3,... -> dot=0 after enqueues 1-4. dot=1 after enqueue 5, 2 after 6, then din-4 every cycle. Log din on posedge and dot on negedge; the streams must match offset by 4.
- Gapped enq: enqueue 1..4, idle 3 cycles, enqueue 5 -> dot holds 0 through the idle cycles, then becomes 1. Idle after that -> dot holds 1.
- Clear: stream 1..10, then pulse CLR=1 with enq=1 and din=99 -> dot=0, and 99 is not stored. The next 4 enqueues give dot=0; the 5th gives the first post-clear word.
- Wrap: 1000 consecutive enqueues with din=i -> dot=i-4 for all i>4, with no glitch at pointer wrap (wp 3->0).
- Depth sweep: LEN_LOG=1 and LEN_LOG=5 -> delay of exactly 2 and 32 enqueues; repeat with the macro undefined to confirm the one-enqueue-earlier view.

Source files
------------

// File: rtl/single_ch_dcfifo_s.sv
// -----------------------------------------------------------------------------
// single_ch_dcfifo_s
//   Single-channel fixed-depth streaming FIFO (delay line), one clock domain.
//   Each enqueue writes one DW-bit word and presents the word written exactly
//   D = 2**LEN_LOG enqueues earlier. There is no dequeue handshake: the stream
//   drains itself as new data arrives. Until the FIFO has been filled once
//   after reset/clear, the output reads 0 rather than uninitialised storage.
//
// Parameters
//   DW       data width in bits
//   LEN_LOG  log2 of the depth, legal range 1..12
//
// Ports
//   CLK    in   1   clock, all state changes on the rising edge
//   RST_X  in   1   asynchronous reset, active low
//   CLR    in   1   synchronous clear, active high (priority over enq)
//   enq    in   1   enqueue strobe
//   din    in   DW  write data
//   dot    out  DW  read data
//
// Build option
//   SINGLE_CH_DCFIFO_S_OUTREG_EN
//     defined   : dot is a register loaded with the word displaced by the
//                 latest enqueue
//     undefined : dot is combinational and shows the word the next enqueue
//                 will displace (one enqueue earlier than the registered view)
// -----------------------------------------------------------------------------
module single_ch_dcfifo_s #(
   parameter int DW      = 32,
   parameter int LEN_LOG = 2
) (
   input  logic          CLK,
   input  logic          RST_X,
   input  logic          CLR,
   input  logic          enq,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dot
);

   localparam int unsigned D = 1 << LEN_LOG;

   logic [DW-1:0]      mem [D];
   logic [LEN_LOG-1:0] wp_q, wp_d;
   logic [LEN_LOG:0]   fc_q, fc_d;
   logic               full;
   logic               wr_en;
   logic [DW-1:0]      rd_word;

   assign full    = (fc_q == (LEN_LOG+1)'(D));
   assign wr_en   = enq && !CLR;
   // Gate the read with the fill state so stale/unwritten storage never leaks.
   assign rd_word = full ? mem[wp_q] : '0;

   always_comb begin
      wp_d = wp_q;
      fc_d = fc_q;
      if (CLR) begin
         wp_d = '0;
         fc_d = '0;
      end else if (enq) begin
         wp_d = wp_q + 1'b1;
         fc_d = full ? fc_q : fc_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         wp_q <= '0;
         fc_q <= '0;
      end else begin
         wp_q <= wp_d;
         fc_q <= fc_d;
      end
   end

   // Storage carries no reset; the fill gate on rd_word covers its contents.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[wp_q] <= din;
      end
   end

`ifdef SINGLE_CH_DCFIFO_S_OUTREG_EN
   logic [DW-1:0] dot_q, dot_d;

   always_comb begin
      dot_d = dot_q;
      if (CLR) begin
         dot_d = '0;
      end else if (enq) begin
         dot_d = rd_word;
      end
   end

   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         dot_q <= '0;
      end else begin
         dot_q <= dot_d;
      end
   end

   assign dot = dot_q;
`else
   assign dot = rd_word;
`endif

endmodule

// File: tb/tb_single_ch_dcfifo_s.sv
// -----------------------------------------------------------------------------
// tb_single_ch_dcfifo_s
//   Drives three depths (LEN_LOG = 1, 2, 5) from one shared stimulus stream and
//   compares each dot against a queue-based scoreboard on the falling edge.
//   The expectation model follows whichever output build is compiled.
// -----------------------------------------------------------------------------
module tb_single_ch_dcfifo_s;

   typedef logic [31:0] wq_t [$];

   logic        CLK;
   logic        RST_X;
   logic        CLR;
   logic        enq;
   logic [31:0] din;
   logic [31:0] dot1, dot2, dot5;

   int checks   = 0;
   int failures = 0;

   wq_t         q1, q2, q5;
   logic [31:0] e1, e2, e5;

`ifdef SINGLE_CH_DCFIFO_S_OUTREG_EN
   localparam bit OUTREG = 1'b1;
`else
   localparam bit OUTREG = 1'b0;
`endif

   single_ch_dcfifo_s #(.DW(32), .LEN_LOG(1)) u_d1 (
      .CLK(CLK), .RST_X(RST_X), .CLR(CLR), .enq(enq), .din(din), .dot(dot1));
   single_ch_dcfifo_s #(.DW(32), .LEN_LOG(2)) u_d2 (
      .CLK(CLK), .RST_X(RST_X), .CLR(CLR), .enq(enq), .din(din), .dot(dot2));
   single_ch_dcfifo_s #(.DW(32), .LEN_LOG(5)) u_d5 (
      .CLK(CLK), .RST_X(RST_X), .CLR(CLR), .enq(enq), .din(din), .dot(dot5));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard update for one enqueue into a depth-d delay line.
   task automatic upd(input wq_t qi, input int d, input logic [31:0] w,
                      output wq_t qo, output logic [31:0] e);
      qo = qi;
      qo.push_back(w);
      if (OUTREG) begin
         if (qo.size() > d) e = qo.pop_front();
         else               e = '0;
      end else begin
         if (qo.size() > d) void'(qo.pop_front());
         e = (qo.size() == d) ? qo[0] : '0;
      end
   endtask

   task automatic model_clear();
      q1.delete(); q2.delete(); q5.delete();
      e1 = '0; e2 = '0; e5 = '0;
   endtask

   task automatic check_all(input string tag);
      check_eq({tag, "_d1"}, dot1, e1);
      check_eq({tag, "_d2"}, dot2, e2);
      check_eq({tag, "_d5"}, dot5, e5);
   endtask

   // One clock: drive at the falling edge, update model at the rising edge,
   // compare at the next falling edge.
   task automatic cyc(input string tag, input logic c, input logic e,
                      input logic [31:0] w);
      CLR = c; enq = e; din = w;
      @(posedge CLK);
      if (c) begin
         model_clear();
      end else if (e) begin
         upd(q1, 2,  w, q1, e1);
         upd(q2, 4,  w, q2, e2);
         upd(q5, 32, w, q5, e5);
      end
      @(negedge CLK);
      check_all(tag);
   endtask

   initial begin
      RST_X = 1'b0; CLR = 1'b0; enq = 1'b0; din = '0;
      model_clear();
      #12;
      check_all("rst");
      @(negedge CLK);
      RST_X = 1'b1;

      for (int i = 0; i < 10; i++) cyc("idle", 1'b0, 1'b0, 32'd0);

      // Gapped enqueue
      for (int i = 1; i <= 4; i++) cyc("gap_fill", 1'b0, 1'b1, 32'(i));
      for (int i = 0; i < 3; i++)  cyc("gap_idle", 1'b0, 1'b0, 32'hdead);
      cyc("gap5", 1'b0, 1'b1, 32'd5);
      check_eq("gap5_const_d2", dot2, OUTREG ? 32'd1 : 32'd2);
      for (int i = 0; i < 3; i++)  cyc("gap_hold", 1'b0, 1'b0, 32'hbeef);

      // Clear with coincident enqueue of 99
      cyc("clr0", 1'b1, 1'b0, 32'd0);
      for (int i = 1; i <= 10; i++) cyc("pre_clr", 1'b0, 1'b1, 32'(i));
      cyc("clr99", 1'b1, 1'b1, 32'd99);
      check_eq("clr99_zero_d2", dot2, 32'd0);
      for (int i = 0; i < 40; i++) cyc("post_clr", 1'b0, 1'b1, 32'(200 + i));

      // Asynchronous reset asserted mid-cycle while dot is non-zero
      enq = 1'b0;
      @(posedge CLK);
      #2 RST_X = 1'b0;
      #1;
      model_clear();
      check_all("async_rst");
      @(negedge CLK);
      RST_X = 1'b1;
      for (int i = 0; i < 3; i++) cyc("rst_idle", 1'b0, 1'b0, 32'd7);

      // Long stream through many pointer wraps
      for (int i = 1; i <= 1000; i++) cyc("wrap", 1'b0, 1'b1, 32'(i));
      check_eq("wrap_end_d2", dot2, OUTREG ? 32'd996 : 32'd997);

      // Random gaps and occasional clears
      for (int i = 0; i < 300; i++) begin
         cyc("rand", ($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
             $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
